// File: rtl/fc_argmax.sv
// Streaming argmax over NUM_CLASSES signed logits per frame; holds the result until accepted.
// Optional FC_ARGMAX_MARGIN_EN adds out_margin (best minus second-best) and the second-best tracker.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_class,
  output logic [DATA_W-1:0]        out_score,
  output logic                     out_err
`ifdef FC_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W-1:0]        out_margin
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0]         LAST_CNT = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      err_q, err_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic [IDX_W-1:0]          out_class_q, out_class_d;
  logic [DATA_W-1:0]         out_score_q, out_score_d;
  logic                      out_err_q, out_err_d;

  logic beat;
  logic final_beat;
  logic err_beat;

`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0]  second_q, second_d;
  logic [DATA_W-1:0]         out_margin_q, out_margin_d;
  logic signed [DATA_W:0]    margin_wide;
`endif

  assign beat       = in_valid && in_ready_q;
  assign final_beat = (cnt_q == LAST_CNT);
  // in_last must appear on the final beat and nowhere else
  assign err_beat   = in_last ^ final_beat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    idx_d       = idx_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    out_err_d   = out_err_q;
`ifdef FC_ARGMAX_MARGIN_EN
    second_d     = second_q;
    out_margin_d = out_margin_q;
    margin_wide  = '0;
`endif

    case (state_q)
      ACCUM: begin
        if (!in_ready_q) begin
          // first cycle out of reset
          in_ready_d = 1'b1;
        end else if (beat) begin
          if (cnt_q == '0) begin
            best_d = in_data;
            idx_d  = '0;
            err_d  = err_beat;
`ifdef FC_ARGMAX_MARGIN_EN
            second_d = S_MIN;
`endif
          end else begin
            err_d = err_q | err_beat;
            if (in_data > best_q) begin
              best_d = in_data;
              idx_d  = cnt_q;
`ifdef FC_ARGMAX_MARGIN_EN
              second_d = best_q;
            end else if (in_data > second_q) begin
              second_d = in_data;
`endif
            end
          end

          if (final_beat) begin
            state_d     = HOLD;
            cnt_d       = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_class_d = idx_d;
            out_score_d = best_d;
            out_err_d   = err_d;
`ifdef FC_ARGMAX_MARGIN_EN
            margin_wide  = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
            out_margin_d = margin_wide[DATA_W-1:0];
`endif
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      out_err_q   <= 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q     <= S_MIN;
      out_margin_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      out_err_q   <= out_err_d;
`ifdef FC_ARGMAX_MARGIN_EN
      second_q     <= second_d;
      out_margin_q <= out_margin_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign out_err   = out_err_q;
`ifdef FC_ARGMAX_MARGIN_EN
  assign out_margin = out_margin_q;
`endif

endmodule

// File: doc/fc_argmax.md
# fc_argmax

Streaming classifier head that consumes the logits produced by the fully connected layer, one signed logit per beat, and reports the winning class index and its score. It sits directly downstream of the FC stage and is the last compute block before the result is sent to the host/display. A frame is exactly `NUM_CLASSES` beats. The block holds its result until the consumer accepts it.

## Interface
Parameters:
- `NUM_CLASSES`, default 10: logits per frame; must be 1 to 16.
- `DATA_W`, default 16: logit width, signed two's complement.
- `IDX_W`, default 4: class index width; must satisfy `2**IDX_W >= NUM_CLASSES`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: logit beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in `DATA_W`: signed logit; beat k carries class k.
- `in_last` in 1: producer's end-of-frame marker, used only for checking.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_class` out `IDX_W`: argmax index.
- `out_score` out `DATA_W`: maximum logit, signed.
- `out_err` out 1: framing error in this frame.
- `out_margin` out `DATA_W`: unsigned value, best minus second-best. Present only with `FC_ARGMAX_MARGIN_EN`.

## Operation
- Two states, `ACCUM` and `HOLD`.
- A beat transfers when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- **ACCUM** (`in_ready`=1, `out_valid`=0). A beat counter `cnt` runs 0..`NUM_CLASSES-1`.
  - Beat with `cnt==0`: `best`=data, `idx`=0, `second`=most-negative value (`-2**(DATA_W-1)`), `err`=0.
  - Beat with `cnt>0`, compared signed:
    - if data > `best`: `second`=`best`, `best`=data, `idx`=`cnt`;
    - else if data > `second`: `second`=data.
  - Comparisons are strict, so on a tie the lowest index wins.
  - Framing check: `err` is set sticky if `in_last`=1 on any beat with `cnt<NUM_CLASSES-1`, or if `in_last`=0 on the final beat.
  - Framing is by count only. `in_last` never shortens or extends a frame.
  - The final beat (`cnt==NUM_CLASSES-1`) moves the block to HOLD and clears `cnt`.
- **HOLD** (`in_ready`=0, `out_valid`=1).
  - `out_class`, `out_score`, `out_err` and `out_margin` are registered and stable until the result transfers.
  - When the result transfers, the block returns to ACCUM.
- Gaps on either interface (`in_valid`=0 mid-frame, or `out_ready` held low) are legal and stall without changing state.
- `NUM_CLASSES`=1: every beat is a full frame, `out_class`=0.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_class`=0, `out_score`=0, `out_err`=0, `out_margin`=0.
- After reset, state=ACCUM and `cnt`=0. `in_ready` rises on the first `clk` edge after `rst_n` deasserts.
- Asserting `rst_n`=0 mid-frame or in HOLD aborts immediately. The partial frame is discarded and no result is emitted.
- Latency: `out_valid` rises in the cycle after the final beat transfers.
- On the result transfer edge, `out_valid` falls and `in_ready` rises. The first beat of the next frame can transfer in the following cycle.
- Throughput with both sides always ready: one frame per `NUM_CLASSES+1` cycles.
- `in_ready` and `out_valid` are registered and never high in the same cycle.

## Configuration
- `FC_ARGMAX_MARGIN_EN` defined:
  - The `second` tracker and the `out_margin` port are built.
  - `out_margin` = `best - second`, computed in `DATA_W+1` bits and truncated to `DATA_W` bits unsigned. This is exact, since the difference is always 0 to `2**DATA_W-1`.
  - Registered with the other outputs on entry to HOLD.
- `FC_ARGMAX_MARGIN_EN` undefined:
  - No `second` register and no `out_margin` port.
  - All other behaviour is identical.

## Test plan
All cases use the default parameters (`NUM_CLASSES`=10, `DATA_W`=16).
- **Basic:** logits 5,-3,100,7,0,0,0,0,0,42 with `in_last` on beat 9 and `out_ready`=1. Expect `out_valid` for exactly 1 cycle, the cycle after beat 9. Expect `out_class`=2, `out_score`=100, `out_err`=0, `out_margin`=58.
- **Tie and negative values:** logits all -1000 except beats 3 and 7 = -5. Expect `out_class`=3, `out_score`=-5 (0xFFFB), `out_margin`=0.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after a frame. Expect outputs stable, `in_ready`=0 throughout, and `in_valid` beats not accepted. On `out_ready`=1, one transfer occurs, then `in_ready`=1 on the next cycle.
- **Framing error:** `in_last` on beat 4 of 10. Expect the result only after 10 beats, with `out_err`=1. The next clean frame gives `out_err`=0.
- **Extremes and stalls:** logits 0x8000 ×9 then 0x7FFF, with random `in_valid` gaps. Expect `out_class`=9, `out_score`=32767, `out_margin`=65535.
- **Reset mid-frame:** pulse `rst_n` low after beat 6. Expect all outputs at reset values. A following complete 10-beat frame produces the correct single result.
